// File: rtl/fs_serial_pkg.sv
// rtl/fs_serial_pkg.sv - shared parameters, FSM states and helpers for the FS serial capture
package fs_serial_pkg;

    localparam int WORD_BITS = 32;
    localparam int ADDR_BITS = 3;
    localparam int NUM_REGS  = 6;
    localparam int CNT_BITS  = 6;
    localparam int FCNT_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_e;

    function automatic logic addr_ok(input logic [ADDR_BITS-1:0] a);
        return a < ADDR_BITS'(NUM_REGS);
    endfunction

endpackage

// File: rtl/fs_serial_capture_if.sv
// rtl/fs_serial_capture_if.sv - 3-wire bus, readback port and frame status signals
interface fs_serial_capture_if;
    import fs_serial_pkg::*;

    logic                  sclkIN;
    logic                  sdataIN;
    logic                  leIN;
    logic [ADDR_BITS-1:0]  rdAddrIN;
    logic [WORD_BITS-1:0]  rdDataOUT;
    logic [WORD_BITS-1:0]  wordOUT;
    logic [ADDR_BITS-1:0]  addrOUT;
    logic                  validOUT;
    logic                  errOUT;
    logic [FCNT_BITS-1:0]  frameCntOUT;

    modport master (
        output sclkIN, sdataIN, leIN, rdAddrIN,
        input  rdDataOUT, wordOUT, addrOUT, validOUT, errOUT, frameCntOUT
    );

    modport slave (
        input  sclkIN, sdataIN, leIN, rdAddrIN,
        output rdDataOUT, wordOUT, addrOUT, validOUT, errOUT, frameCntOUT
    );

endinterface

// File: rtl/fs_sync_edge.sv
// rtl/fs_sync_edge.sv - 2-flop synchronizer with registered rise/fall detect
module fs_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q, sync_q, prev_q, rise_q, fall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
            fall_q <= ~sync_q & prev_q;
        end
    end

    // Level taken from the same stage as the edge pulses so data lines up with its clock edge.
    assign sync_o = prev_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/fs_serial_capture.sv
// rtl/fs_serial_capture.sv - deserializes FS programming frames into a 6-entry register bank
module fs_serial_capture
    import fs_serial_pkg::*;
(
    input  logic               clkIN,
    input  logic               nResetIN,
    fs_serial_capture_if.slave bus
);

    localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(WORD_BITS);

    logic sclk_s, sclk_rise, sclk_fall;
    logic sdata_s, sdata_rise, sdata_fall;
    logic le_s, le_rise, le_fall;
    logic unused_edges;

    fs_sync_edge u_sync_sclk (.clk_i(clkIN), .rst_ni(nResetIN), .d_i(bus.sclkIN),
                              .sync_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall));
    fs_sync_edge u_sync_sdata (.clk_i(clkIN), .rst_ni(nResetIN), .d_i(bus.sdataIN),
                               .sync_o(sdata_s), .rise_o(sdata_rise), .fall_o(sdata_fall));
    fs_sync_edge u_sync_le (.clk_i(clkIN), .rst_ni(nResetIN), .d_i(bus.leIN),
                            .sync_o(le_s), .rise_o(le_rise), .fall_o(le_fall));

    assign unused_edges = sclk_s ^ sclk_fall ^ sdata_rise ^ sdata_fall ^ le_s;

    state_e                 state_q, state_d;
    logic [WORD_BITS-1:0]   shift_q, shift_d;
    logic [CNT_BITS-1:0]    cnt_q, cnt_d;
    logic [WORD_BITS-1:0]   bank_q [NUM_REGS];
    logic [WORD_BITS-1:0]   word_q, rd_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [FCNT_BITS-1:0]   frame_q;
    logic                   accept, reject;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        reject  = 1'b0;
        case (state_q)
            IDLE: begin
                if (le_fall) begin
                    state_d = SHIFT;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                // A bit arriving in the same cycle as the latch edge is dropped.
                if (le_rise) begin
                    state_d = LATCH;
                end else if (sclk_rise) begin
                    shift_d = {shift_q[WORD_BITS-2:0], sdata_s};
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_BITS'(1);
                    end
                end
            end
            LATCH: begin
                state_d = IDLE;
                if (cnt_q == CNT_FULL && addr_ok(shift_q[ADDR_BITS-1:0])) begin
                    accept = 1'b1;
                end else begin
                    reject = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            addr_q  <= '0;
            frame_q <= '0;
            rd_q    <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                bank_q[shift_q[ADDR_BITS-1:0]] <= shift_q;
                word_q  <= shift_q;
                addr_q  <= shift_q[ADDR_BITS-1:0];
                frame_q <= frame_q + FCNT_BITS'(1);
            end
            // Reads see the bank before this cycle's write.
            rd_q <= addr_ok(bus.rdAddrIN) ? bank_q[bus.rdAddrIN] : '0;
        end
    end

    assign bus.validOUT    = accept;
    assign bus.errOUT      = reject;
    assign bus.wordOUT     = word_q;
    assign bus.addrOUT     = addr_q;
    assign bus.frameCntOUT = frame_q;
    assign bus.rdDataOUT   = rd_q;

endmodule

// File: tb/tb_fs_serial_capture.sv
// tb/tb_fs_serial_capture.sv - directed and randomized frames against a frame-level model
module tb_fs_serial_capture;
    import fs_serial_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    fs_serial_capture_if bus();

    fs_serial_capture dut (
        .clkIN    (clk),
        .nResetIN (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int v_total  = 0;
    int e_total  = 0;

    logic [31:0] mdl_bank [8];
    logic [31:0] mdl_word;
    logic [2:0]  mdl_addr;
    logic [7:0]  mdl_cnt;

    always @(negedge clk) begin
        if (bus.validOUT === 1'b1) v_total++;
        if (bus.errOUT === 1'b1) e_total++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mdl_bank[i] = '0;
        mdl_word = '0;
        mdl_addr = '0;
        mdl_cnt  = '0;
    endtask

    task automatic model_frame(input logic [63:0] v, input int n, output bit acc);
        acc = (n == 32) && (v[2:0] < 3'd6);
        if (acc) begin
            mdl_bank[v[2:0]] = v[31:0];
            mdl_word = v[31:0];
            mdl_addr = v[2:0];
            mdl_cnt  = mdl_cnt + 8'd1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        tick(3);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic send_bits(input logic [63:0] v, input int first, input int last);
        for (int i = first; i >= last; i--) begin
            bus.sdataIN = v[i];
            bus.sclkIN  = 1'b0;
            tick(2);
            bus.sclkIN  = 1'b1;
            tick(2);
        end
        bus.sclkIN = 1'b0;
    endtask

    task automatic end_frame(output int vc, output int vp, output int ec, output int ep,
                             output logic [31:0] rd_old, output logic [31:0] rd_new);
        vc = 0; vp = 0; ec = 0; ep = 0;
        rd_old = 'x; rd_new = 'x;
        bus.leIN = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick(1);
            if (bus.validOUT === 1'b1) begin vc++; if (vp == 0) vp = c; end
            if (bus.errOUT === 1'b1) begin ec++; if (ep == 0) ep = c; end
            if (c == 5) rd_old = bus.rdDataOUT;
            if (c == 6) rd_new = bus.rdDataOUT;
        end
    endtask

    task automatic do_frame(input string tag, input logic [63:0] v, input int n,
                            input logic [2:0] rd_addr);
        int vc, vp, ec, ep;
        logic [31:0] ro, rn, exp_old;
        bit acc;
        bus.rdAddrIN = rd_addr;
        bus.leIN = 1'b0;
        tick(2);
        send_bits(v, n - 1, 0);
        exp_old = mdl_bank[rd_addr];
        model_frame(v, n, acc);
        end_frame(vc, vp, ec, ep, ro, rn);
        check({tag, ".valid_cnt"}, vc, acc ? 1 : 0);
        check({tag, ".valid_pos"}, vp, acc ? 4 : 0);
        check({tag, ".err_cnt"}, ec, acc ? 0 : 1);
        check({tag, ".err_pos"}, ep, acc ? 0 : 4);
        check({tag, ".rd_old"}, ro, exp_old);
        check({tag, ".rd_new"}, rn, mdl_bank[rd_addr]);
        check({tag, ".word"}, bus.wordOUT, mdl_word);
        check({tag, ".addr"}, {29'd0, bus.addrOUT}, {29'd0, mdl_addr});
        check({tag, ".fcnt"}, {24'd0, bus.frameCntOUT}, {24'd0, mdl_cnt});
    endtask

    task automatic sweep_bank(input string tag);
        for (int a = 0; a < 8; a++) begin
            bus.rdAddrIN = 3'(a);
            tick(1);
            check($sformatf("%s.rd%0d", tag, a), bus.rdDataOUT, mdl_bank[a]);
        end
    endtask

    initial begin
        int vc, vp, ec, ep, vb, eb, nb;
        logic [31:0] ro, rn, w;
        logic [63:0] v;
        logic [2:0] ra;
        bit acc;

        bus.sclkIN   = 1'b0;
        bus.sdataIN  = 1'b0;
        bus.leIN     = 1'b1;
        bus.rdAddrIN = '0;

        // Reset with the bus idle and LE high.
        do_reset();
        check("rst.valid", {31'd0, bus.validOUT}, 32'd0);
        check("rst.err", {31'd0, bus.errOUT}, 32'd0);
        check("rst.word", bus.wordOUT, 32'd0);
        check("rst.addr", {29'd0, bus.addrOUT}, 32'd0);
        check("rst.fcnt", {24'd0, bus.frameCntOUT}, 32'd0);
        check("rst.rd", bus.rdDataOUT, 32'd0);
        sweep_bank("rst");
        check("rst.no_pulse", v_total + e_total, 0);

        do_frame("f15", 64'h15, 32, 3'd5);
        do_frame("short31", 64'h7FFF_0002, 31, 3'd5);
        do_frame("long33", 64'h1_2345_6781, 33, 3'd5);
        do_frame("bad_addr7", 64'hABCD_0007, 32, 3'd7);
        do_frame("bad_addr6", 64'h1111_0006, 32, 3'd6);
        do_frame("max_addr5", 64'hFFFF_FFFD, 32, 3'd5);

        // Reset mid-frame: the tail of the interrupted frame must be ignored.
        v = 64'hDEAD_BEE3;
        bus.leIN = 1'b0;
        tick(2);
        send_bits(v, 31, 16);
        rst_n = 1'b0;
        model_reset();
        tick(2);
        rst_n = 1'b1;
        send_bits(v, 15, 0);
        end_frame(vc, vp, ec, ep, ro, rn);
        check("midrst.valid_cnt", vc, 0);
        check("midrst.err_cnt", ec, 0);
        check("midrst.fcnt", {24'd0, bus.frameCntOUT}, 32'd0);
        check("midrst.word", bus.wordOUT, 32'd0);
        w = $urandom();
        w[2:0] = 3'd0;
        do_frame("addr0", {32'd0, w}, 32, 3'd0);

        for (int k = 0; k < 16; k++) begin
            v = {$urandom(), $urandom()};
            case ($urandom_range(0, 5))
                0: nb = 31;
                1: nb = 33;
                default: nb = 32;
            endcase
            ra = 3'($urandom_range(0, 7));
            do_frame($sformatf("rnd%0d", k), v, nb, ra);
        end
        sweep_bank("post_rnd");

        // 256 back-to-back frames with minimum LE-high spacing; count must wrap to 0.
        do_reset();
        vb = v_total;
        eb = e_total;
        ra = '0;
        for (int k = 0; k < 256; k++) begin
            w = $urandom();
            w[2:0] = 3'($urandom_range(0, 5));
            ra = w[2:0];
            bus.leIN = 1'b0;
            tick(2);
            send_bits({32'd0, w}, 31, 0);
            model_frame({32'd0, w}, 32, acc);
            bus.leIN = 1'b1;
            tick(2);
        end
        tick(6);
        check("b2b.valids", v_total - vb, 256);
        check("b2b.errs", e_total - eb, 0);
        check("b2b.fcnt", {24'd0, bus.frameCntOUT}, {24'd0, mdl_cnt});
        check("b2b.fcnt_wrapped", {24'd0, bus.frameCntOUT}, 32'd0);
        check("b2b.word", bus.wordOUT, mdl_word);
        bus.rdAddrIN = ra;
        tick(2);
        check("b2b.last_rd", bus.rdDataOUT, mdl_word);
        sweep_bank("b2b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
